// File: rtl/ex_decimator_pkg.sv
// ex_decim_pkg: constants and helpers shared by the decimator slice.
//   DECIM_LOG2_MAX : largest supported log2 decimation factor
//   SAMPLE_W       : width of input/output samples
//   acc_width()    : accumulator width needed for 2^decim_log2 samples
package ex_decim_pkg;

    localparam int DECIM_LOG2_MAX = 8;
    localparam int SAMPLE_W       = 32;

    function automatic int acc_width(input int decim_log2);
        return SAMPLE_W + decim_log2;
    endfunction

endpackage

// File: rtl/ex_decimator_if.sv
// ex_decimator_if: sample input strobe plus valid/ready result port.
//   data_in, data_in_valid        : upstream sample stream (no backpressure)
//   data_out, data_out_valid      : decimated result, held until accepted
//   data_out_ready                : downstream accept
//   overrun                       : sticky, a completed result was dropped
//   modport slave  : the decimator
//   modport master : the environment driving samples and consuming results
interface ex_decimator_if;
    import ex_decim_pkg::*;

    logic signed [SAMPLE_W-1:0] data_in;
    logic                       data_in_valid;
    logic signed [SAMPLE_W-1:0] data_out;
    logic                       data_out_valid;
    logic                       data_out_ready;
    logic                       overrun;

    modport slave (
        input  data_in,
        input  data_in_valid,
        input  data_out_ready,
        output data_out,
        output data_out_valid,
        output overrun
    );

    modport master (
        output data_in,
        output data_in_valid,
        output data_out_ready,
        input  data_out,
        input  data_out_valid,
        input  overrun
    );

endinterface

// File: rtl/ex_decimator_out_stage.sv
// ex_out_stage: output holding register for decimated results.
//   clk, rst        : clock, synchronous active-high reset
//   load, result    : block completed this cycle with this value
//   ready           : downstream accepts data_out this cycle
//   data_out        : held result (stable while valid and not ready)
//   data_out_valid  : data_out holds an undelivered result
//   overrun         : sticky, set when a completed result had nowhere to go
module ex_out_stage
    import ex_decim_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic signed [SAMPLE_W-1:0] result,
    input  logic                       ready,
    output logic signed [SAMPLE_W-1:0] data_out,
    output logic                       data_out_valid,
    output logic                       overrun
);

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            overrun        <= 1'b0;
        end else if (load) begin
            // The slot is free if empty or being drained this same cycle.
            if (!data_out_valid || ready) begin
                data_out       <= result;
                data_out_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (data_out_valid && ready) begin
            data_out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_decimator.sv
// ex_decimator: averages blocks of 2^decim_log2 signed samples.
//   parameter decim_log2 : log2 of the decimation factor (0..8, 0 = pass-through)
//   clk, rst             : clock, synchronous active-high reset
//   bus (slave)          : sample input strobe, valid/ready result, overrun
// Build option EX_DECIMATOR_ROUND_EN: round half up instead of truncating
// toward -inf when dividing the block sum.
module ex_decimator
    import ex_decim_pkg::*;
#(
    parameter int decim_log2 = 2
) (
    input  logic          clk,
    input  logic          rst,
    ex_decimator_if.slave bus
);

    localparam int               ACC_W    = acc_width(decim_log2);
    localparam int               CNT_W    = (decim_log2 > 0) ? decim_log2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << decim_log2) - 1);

    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    din_ext;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    sum_adj;
    logic        [CNT_W-1:0]    cnt;
    logic                       block_done;
    logic signed [SAMPLE_W-1:0] result;

    assign din_ext    = ACC_W'(bus.data_in);
    assign sum        = acc + din_ext;
    assign block_done = bus.data_in_valid && (cnt == CNT_LAST);

`ifdef EX_DECIMATOR_ROUND_EN
    if (decim_log2 > 0) begin : g_round
        assign sum_adj = sum + (ACC_W'(1) << (decim_log2 - 1));
    end else begin : g_no_round
        assign sum_adj = sum;
    end
`else
    assign sum_adj = sum;
`endif

    // The mean of N in-range samples always fits back in SAMPLE_W bits.
    assign result = SAMPLE_W'(sum_adj >>> decim_log2);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (bus.data_in_valid) begin
            if (block_done) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    ex_out_stage u_out_stage (
        .clk            (clk),
        .rst            (rst),
        .load           (block_done),
        .result         (result),
        .ready          (bus.data_out_ready),
        .data_out       (bus.data_out),
        .data_out_valid (bus.data_out_valid),
        .overrun        (bus.overrun)
    );

endmodule

// File: doc/ex_decimator.md
# ex_decimator

Downstream consumer of the example data stage: takes the signed 32-bit sample stream and its valid strobe, and accumulates 2^decim_log2 consecutive samples. It emits one averaged signed 32-bit sample per block on a valid/ready output port. Upstream has no backpressure, so results that cannot be delivered are dropped and flagged with a sticky overrun bit.

## Interface
- decim_log2, default 2, log2 of the decimation factor N; legal range 0..8; 0 passes every sample through.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- data_in  input  32  signed sample from the upstream stage's data_out.
- data_in_valid  input  1  sample strobe, driven from the upstream stage's data_valid.
- data_out  output  32  signed decimated sample.
- data_out_valid  output  1  data_out holds an undelivered result.
- data_out_ready  input  1  downstream accepts data_out this cycle.
- overrun  output  1  sticky; a completed result was dropped.

## Operation
- Accumulator acc, signed, width 32+decim_log2; sample counter cnt, range 0..N-1.
- When data_in_valid=1 and cnt<N-1:
  - acc <= acc + data_in
  - cnt <= cnt+1
- When data_in_valid=1 and cnt=N-1 (block completes):
  - sum = acc + data_in
  - result = sum >>> decim_log2 (arithmetic shift; see Configuration)
  - acc <= 0, cnt <= 0
- When data_in_valid=0: acc and cnt hold.
- Output register update on block completion:
  - Loaded when data_out_valid=0, or when data_out_valid=1 and data_out_ready=1 in the same cycle.
  - Otherwise the new result is discarded, the old data_out is kept, and overrun <= 1.
- When data_out_valid=1 and data_out_ready=1 with no completion that cycle, data_out_valid <= 0.
- overrun clears only on rst.
- No arithmetic overflow is possible: the mean of N in-range 32-bit values stays in range, including with rounding.

## Timing
- Reset values:
  - data_out=0, data_out_valid=0, overrun=0
  - acc=0, cnt=0
- Latency: the completing sample at cycle t gives data_out_valid=1 with the result at cycle t+1.
- Maximum throughput: one result per cycle when decim_log2=0 and data_out_ready is held high.
- data_out is stable while data_out_valid=1 and data_out_ready=0.
- Simultaneous completion and acceptance in the same cycle: the new result replaces the old one, data_out_valid stays 1, no overrun.
- rst asserted mid-block: the partial accumulation is discarded, and the next block starts from the first sample after rst deasserts.
- rst has priority over data_in_valid in the same cycle.

## Configuration
- Macro: EX_DECIMATOR_ROUND_EN.
- Defined: result = (sum + 2^(decim_log2-1)) >>> decim_log2 (round half up). No rounding term is added when decim_log2=0.
- Undefined: result = sum >>> decim_log2 (truncation toward -inf).
- Latency, handshake and overrun behaviour are identical in both builds.

## Structure
- Shared package ex_decim_pkg holds:
  - DECIM_LOG2_MAX = 8
  - SAMPLE_W = 32
  - function acc_width(decim_log2) = SAMPLE_W + decim_log2
- One sub-module, ex_out_stage: the output holding register. It implements valid/ready, load-or-drop on block completion, and the sticky overrun flag.
- Accumulator, counter and shift/round logic live in the top module.

## Test plan
- decim_log2=2, ready=1, samples 1,2,3,4:
  - data_out=3 with ROUND_EN
  - data_out=2 without
  - valid rises one cycle after the 4th strobe
- decim_log2=2, samples -1,-1,-1,-2 (sum -5):
  - data_out=-1 with ROUND_EN
  - data_out=-2 without
- decim_log2=2, four samples 0x7FFFFFFF then four samples 0x80000000: outputs 0x7FFFFFFF then 0x80000000 in both builds.
- decim_log2=0, ready=0, samples 5 then 6:
  - data_out stays 5, overrun=1
  - ready=1 for one cycle then drops: valid falls, overrun stays 1
- decim_log2=0, ready=1, samples 7,8,9 on consecutive cycles: outputs 7,8,9 on consecutive cycles, valid held high, overrun=0.
- decim_log2=3, samples 100,100, then rst one cycle, then eight samples of 8: the single output is 8 and the pre-reset samples have no effect.
